// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin adder arbiter.
//   NREQ    : number of requesters (fixed at 8)
//   IDW     : width of a requester index
//   state_e : sequencer states IDLE / EXEC
//   onehot8 : index -> one-hot grant/ack vector
package arb_pkg;

  localparam int unsigned NREQ = 8;
  localparam int unsigned IDW  = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] onehot8(input logic [IDW-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Requester-side bus of the shared adder arbiter.
//   req          : level request per requester
//   op_a, op_b   : flattened operands, slice i = op_x[i*WIDTH +: WIDTH]
//   lock         : keep the pointer on the winner (only with ARB_LOCK_EN)
//   ack          : one-hot completion pulse
//   result       : registered sum, result_id its owner, result_valid its pulse
//   busy         : adder sequencer is executing
// modport master = requester side, modport slave = arbiter side.
interface adder_rr_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  import arb_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
`ifdef ARB_LOCK_EN
  logic [NREQ-1:0]       lock;
`endif
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      result;
  logic [IDW-1:0]        result_id;
  logic                  result_valid;
  logic                  busy;

`ifdef ARB_LOCK_EN
  modport master (
    output req, op_a, op_b, lock,
    input  ack, result, result_id, result_valid, busy
  );
  modport slave (
    input  req, op_a, op_b, lock,
    output ack, result, result_id, result_valid, busy
  );
`else
  modport master (
    output req, op_a, op_b,
    input  ack, result, result_id, result_valid, busy
  );
  modport slave (
    input  req, op_a, op_b,
    output ack, result, result_id, result_valid, busy
  );
`endif

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   i_eff   : eligible requesters
//   i_ptr   : highest-priority index this round
//   o_valid : at least one requester eligible
//   o_id    : first eligible index scanning ptr, ptr+1, ... (mod 8)
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] i_eff,
  input  logic [IDW-1:0]  i_ptr,
  output logic            o_valid,
  output logic [IDW-1:0]  o_id
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW-1:0]    w_off;

  // Rotate right by ptr so the pointer position lands on bit 0.
  assign w_dbl = {i_eff, i_eff} >> i_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  // Lowest set bit wins: scan downwards so the last hit is the lowest.
  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDW'(i);
    end
  end

  assign o_valid = |i_eff;
  assign o_id    = w_off + i_ptr;  // wraps mod 8 in IDW bits

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among 8 requesters.
// IDLE picks a requester and captures its operands; EXEC registers the
// sum, owner id and a one-cycle ack/result_valid, then returns to IDLE.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : adder_rr_arbiter_if.slave (req/op_a/op_b in, ack/result/... out)
// Optional: define ARB_LOCK_EN to add bus.lock; a locked winner keeps the
// pointer so it wins the next arbitration it takes part in.
module adder_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  adder_rr_arbiter_if.slave bus
);

  state_e           r_state, w_state_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [IDW-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [NREQ-1:0]  r_ack, w_ack_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [IDW-1:0]   r_result_id, w_result_id_nxt;
  logic             r_result_valid, w_result_valid_nxt;

  logic [NREQ-1:0]  w_eff;
  logic             w_pick_valid;
  logic [IDW-1:0]   w_pick_id;

  // The requester acked this cycle may still hold req; keep it out.
  assign w_eff = bus.req & ~r_ack;

  rr_pick u_pick (
    .i_eff   (w_eff),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_id    (w_pick_id)
  );

  always_comb begin
    w_state_nxt        = r_state;
    w_ptr_nxt          = r_ptr;
    w_gnt_id_nxt       = r_gnt_id;
    w_a_nxt            = r_a;
    w_b_nxt            = r_b;
    w_ack_nxt          = '0;
    w_result_nxt       = r_result;
    w_result_id_nxt    = r_result_id;
    w_result_valid_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_gnt_id_nxt = w_pick_id;
          w_a_nxt      = bus.op_a[w_pick_id*WIDTH +: WIDTH];
          w_b_nxt      = bus.op_b[w_pick_id*WIDTH +: WIDTH];
          w_state_nxt  = EXEC;
        end
      end
      EXEC: begin
        w_result_nxt       = r_a + r_b;  // carry-out dropped
        w_result_id_nxt    = r_gnt_id;
        w_result_valid_nxt = 1'b1;
        w_ack_nxt          = onehot8(r_gnt_id);
        w_ptr_nxt          = r_gnt_id + IDW'(1);
`ifdef ARB_LOCK_EN
        if (bus.lock[r_gnt_id]) w_ptr_nxt = r_gnt_id;
`endif
        w_state_nxt        = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_ptr          <= '0;
      r_gnt_id       <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_ack          <= '0;
      r_result       <= '0;
      r_result_id    <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ptr          <= w_ptr_nxt;
      r_gnt_id       <= w_gnt_id_nxt;
      r_a            <= w_a_nxt;
      r_b            <= w_b_nxt;
      r_ack          <= w_ack_nxt;
      r_result       <= w_result_nxt;
      r_result_id    <= w_result_id_nxt;
      r_result_valid <= w_result_valid_nxt;
    end
  end

  assign bus.ack          = r_ack;
  assign bus.result       = r_result;
  assign bus.result_id    = r_result_id;
  assign bus.result_valid = r_result_valid;
  assign bus.busy         = (r_state == EXEC);

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter.
module tb_adder_rr_arbiter;

  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  adder_rr_arbiter_if #(.WIDTH(W)) bus ();

  adder_rr_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_a[i*W +: W] = a;
    bus.op_b[i*W +: W] = b;
  endtask

  task automatic test_reset();
    n_chk++; if (bus.ack !== 8'h00) begin n_err++; $display("FAIL reset_ack got=%h exp=00", bus.ack); end
    n_chk++; if (bus.result !== 32'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    n_chk++; if (bus.result_id !== 3'd0) begin n_err++; $display("FAIL reset_id got=%0d exp=0", bus.result_id); end
    n_chk++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.result_valid); end
    n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_chk++;
      if (bus.ack !== 8'h00 || bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_quiet cyc=%0d ack=%h valid=%b busy=%b exp=00/0/0",
                 k, bus.ack, bus.result_valid, bus.busy);
      end
    end
  endtask

  task automatic test_basic();
    set_ops(2, 32'h0000_0005, 32'h0000_0007);
    bus.req = 8'h04;
    tick();
    n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
    n_chk++; if (bus.ack !== 8'h00) begin n_err++; $display("FAIL basic_early_ack got=%h exp=00", bus.ack); end
    tick();
    n_chk++; if (bus.ack !== 8'h04) begin n_err++; $display("FAIL basic_ack got=%h exp=04", bus.ack); end
    n_chk++; if (bus.result !== 32'h0000_000C) begin n_err++; $display("FAIL basic_result got=%h exp=0000000c", bus.result); end
    n_chk++; if (bus.result_id !== 3'd2) begin n_err++; $display("FAIL basic_id got=%0d exp=2", bus.result_id); end
    n_chk++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", bus.result_valid); end
    n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_ack got=%b exp=0", bus.busy); end
    bus.req = 8'h00;
    tick();
    n_chk++; if (bus.ack !== 8'h00 || bus.result_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse ack=%h valid=%b exp=00/0", bus.ack, bus.result_valid); end
    n_chk++; if (bus.result !== 32'h0000_000C || bus.result_id !== 3'd2) begin n_err++; $display("FAIL basic_hold result=%h id=%0d exp=0000000c/2", bus.result, bus.result_id); end
  endtask

  task automatic test_overflow();
    set_ops(0, 32'hFFFF_FFFF, 32'h0000_0002);
    bus.req = 8'h01;
    tick();
    tick();
    n_chk++; if (bus.ack !== 8'h01) begin n_err++; $display("FAIL ovf_ack got=%h exp=01", bus.ack); end
    n_chk++; if (bus.result !== 32'h0000_0001) begin n_err++; $display("FAIL ovf_result got=%h exp=00000001", bus.result); end
    n_chk++; if (bus.result_id !== 3'd0) begin n_err++; $display("FAIL ovf_id got=%0d exp=0", bus.result_id); end
    bus.req = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid();
    set_ops(3, 32'h10, 32'h20);
    bus.req = 8'h08;
    tick();
    n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy got=%b exp=1", bus.busy); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.result !== 32'h0 || bus.result_id !== 3'd0 ||
        bus.ack !== 8'h00 || bus.result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_clear busy=%b result=%h id=%0d ack=%h valid=%b exp=all zero",
               bus.busy, bus.result, bus.result_id, bus.ack, bus.result_valid);
    end
    bus.req = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_chk++; if (bus.ack !== 8'h00 || bus.result !== 32'h0) begin n_err++; $display("FAIL rstmid_noack ack=%h result=%h exp=00/0", bus.ack, bus.result); end
  endtask

  task automatic test_fairness();
    int prev;
    prev = -1;
    for (int i = 0; i < 8; i++) set_ops(i, i, 32'h100);
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      int e;
      e = k % 8;
      tick();
      n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL fair_busy op=%0d got=%b exp=1", k, bus.busy); end
      if (prev >= 0) bus.req[prev] = 1'b1;
      tick();
      n_chk++;
      if (bus.ack !== (8'h01 << e) || bus.result_id !== 3'(e) ||
          bus.result !== (32'h100 + 32'(e)) || bus.result_valid !== 1'b1) begin
        n_err++;
        $display("FAIL fair_grant op=%0d ack=%h id=%0d result=%h valid=%b exp_id=%0d",
                 k, bus.ack, bus.result_id, bus.result, bus.result_valid, e);
      end
      bus.req[e] = 1'b0;
      prev = e;
    end
    bus.req = 8'h00;
    tick();
    n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL fair_drain busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_wrap();
    set_ops(5, 32'h1, 32'h2);
    set_ops(6, 32'h3, 32'h4);
    set_ops(0, 32'h5, 32'h6);
    bus.req = 8'h20;
    tick();
    tick();
    n_chk++; if (bus.ack !== 8'h20 || bus.result !== 32'h3) begin n_err++; $display("FAIL wrap_g5 ack=%h result=%h exp=20/3", bus.ack, bus.result); end
    bus.req = 8'h41;
    tick();
    tick();
    n_chk++; if (bus.ack !== 8'h40 || bus.result_id !== 3'd6 || bus.result !== 32'h7) begin n_err++; $display("FAIL wrap_g6 ack=%h id=%0d result=%h exp=40/6/7", bus.ack, bus.result_id, bus.result); end
    tick();
    n_chk++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL wrap_busy got=%b exp=1", bus.busy); end
    tick();
    n_chk++; if (bus.ack !== 8'h01 || bus.result_id !== 3'd0 || bus.result !== 32'hB) begin n_err++; $display("FAIL wrap_g0 ack=%h id=%0d result=%h exp=01/0/b", bus.ack, bus.result_id, bus.result); end
    bus.req = 8'h00;
    tick();
    n_chk++; if (bus.busy !== 1'b0 || bus.ack !== 8'h00) begin n_err++; $display("FAIL wrap_drain busy=%b ack=%h exp=0/00", bus.busy, bus.ack); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    set_ops(0, 32'h1, 32'h1);
    set_ops(1, 32'h2, 32'h2);
    // Pointer is 1 here; sole requester 0 wins and locks the pointer to 0.
    bus.lock = 8'h01;
    bus.req  = 8'h01;
    tick();
    tick();
    n_chk++; if (bus.ack !== 8'h01) begin n_err++; $display("FAIL lock_first ack=%h exp=01", bus.ack); end
    for (int r = 0; r < 2; r++) begin
      bus.req = 8'h00;
      tick();
      bus.req = 8'h03;
      tick();
      tick();
      n_chk++; if (bus.ack !== 8'h01) begin n_err++; $display("FAIL lock_repeat rnd=%0d ack=%h exp=01", r, bus.ack); end
    end
    bus.lock = 8'h00;
    bus.req  = 8'h00;
    tick();
    bus.req = 8'h03;
    tick();
    tick();
    n_chk++; if (bus.ack !== 8'h01) begin n_err++; $display("FAIL lock_last0 ack=%h exp=01", bus.ack); end
    bus.req = 8'h00;
    tick();
    bus.req = 8'h03;
    tick();
    tick();
    n_chk++; if (bus.ack !== 8'h02) begin n_err++; $display("FAIL unlock_next ack=%h exp=02", bus.ack); end
    bus.req = 8'h00;
    tick();
  endtask
`endif

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.op_a  = '0;
    bus.op_b  = '0;
`ifdef ARB_LOCK_EN
    bus.lock  = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_overflow();
    test_reset_mid();
    test_fairness();
    test_wrap();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
